simon_sequence_flasher: RTL and testbench
=========================================

# simon_sequence_flasher

Parametrised successor to the two-LED bit flasher. It plays a stored Simon sequence of up to `MAX_LEN` steps across `CHANNELS` one-hot LEDs, with a programmable off-gap and on-time per step. It sits between the sequence generator (which supplies `seq_data` and `seq_len`) and the board LEDs. It uses a start/busy/done handshake so the game FSM can sequence it with the message display and input capture.

## Interface

Parameters:
- `CHANNELS`, 4: number of LEDs/colours, ≥2.
- `MAX_LEN`, 16: maximum sequence steps, ≥1.
- `ON_CYCLES`, 50_000_000: clock cycles each LED is lit per step, ≥1.
- `OFF_CYCLES`, 25_000_000: dark gap before each step, ≥1.
- Derived `SYM_W` = max(1, clog2(CHANNELS)); `IDX_W` = max(1, clog2(MAX_LEN)).

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request playback; sampled only in IDLE.
- `abort` in 1: stop playback immediately.
- `seq_len` in IDX_W+1: steps to play, 0..MAX_LEN; values above MAX_LEN clamp to MAX_LEN.
- `seq_data` in MAX_LEN*SYM_W: step k symbol at `[k*SYM_W +: SYM_W]`.
- `led` out CHANNELS: one-hot lit LED, or all zero.
- `step_idx` out IDX_W: index of the step currently playing.
- `busy` out 1: high while playing.
- `done` out 1: one-cycle pulse when a playback completes normally.

## Operation

- All outputs are registered. Reset values: `led`=0, `step_idx`=0, `busy`=0, `done`=0, state=IDLE, timer=0.
- States: IDLE, GAP, SHOW, FINISH.
- **IDLE:**
  - On `start`=1 and `abort`=0, snapshot `seq_data` and the clamped `seq_len` into internal registers, set `step_idx`=0 and the timer to 0.
  - If the clamped length is 0, go to FINISH; otherwise go to GAP.
  - Input changes after the snapshot have no effect.
- **GAP:** `led`=0. The timer counts 0..OFF_CYCLES-1, then the block enters SHOW and resets the timer.
- **SHOW:**
  - `led` = one-hot of the snapshot symbol at `step_idx`. A symbol ≥ CHANNELS gives all-zero but keeps full timing.
  - The timer counts 0..ON_CYCLES-1.
  - At the end, if `step_idx` = len-1, go to FINISH. Otherwise increment `step_idx` and go to GAP.
- **FINISH:** for one cycle, `done`=1, `busy`=0, `led`=0, then IDLE. `step_idx` holds its last value until the next start.
- `busy`=1 in GAP and SHOW only.
- `abort`=1 in any state: next cycle is IDLE with `led`=0 and `busy`=0. No `done` pulse is produced. Abort wins over a simultaneous `start` or an end-of-step event.
- `start` in any non-IDLE state is ignored; no queuing.
- The timer width is clog2(max(ON_CYCLES, OFF_CYCLES)). It never wraps, because comparison is against the limit minus 1.

## Timing

- Let `start` be sampled in cycle 0, and let L be the clamped length (L≥1).
  - `busy` rises in cycle 1.
  - Step k's GAP occupies cycles 1+k(OFF+ON) .. k(OFF+ON)+OFF.
  - Step k's SHOW occupies the following ON cycles.
  - `done` is high in cycle L(OFF+ON)+1; `busy` is low in that same cycle.
- If L=0, `done` is high in cycle 1 and `busy` never rises.
- A new `start` is accepted in the cycle after `done` at the earliest.
- `abort` sampled in cycle n gives `led`=0 and `busy`=0 in cycle n+1.
- Reset asserted mid-playback forces all outputs to their reset values immediately, without waiting for a clock edge.

## Structure

- Shared package `simon_pkg` holds:
  - the state encoding (IDLE=0, GAP=1, SHOW=2, FINISH=3);
  - board timing constants (`CLK_HZ`, default ON/OFF cycle counts);
  - the `SYM_W`/`IDX_W` helper function.
- One sub-module, `interval_timer`:
  - parametrised width;
  - inputs `clear` and `limit`;
  - output `expire`, a one-cycle pulse when count = limit-1.
  - It is reused by the message display.

## Test plan

Bench parameters: CHANNELS=4, MAX_LEN=8, ON=4, OFF=2.

- Reset released, no start: `led`=0000, `busy`=0, `done`=0 for 20 cycles.
- seq_len=3, seq_data symbols {2,0,3}, start pulse at cycle 0:
  - `led`=0100 in cycles 3–6, 0001 in cycles 9–12, 1000 in cycles 15–18;
  - `done` pulses in cycle 19.
- seq_len=0, start: `done` in cycle 1, `busy` stays 0, `led` stays 0.
- seq_len=15: clamps to 8 steps, and `done` appears in cycle 49.
- Playback of length 4 with `abort` in cycle 10: `led`=0 and `busy`=0 in cycle 11, no `done`. A `start` in cycle 12 replays from step 0.
- `start` re-pulsed mid-playback and seq_data changed mid-playback: ignored, so the original pattern completes unchanged. Asynchronous `reset` in the middle of SHOW clears `led` before the next clock edge.

Source files
------------

// File: rtl/simon_sequence_flasher_pkg.sv
// simon_pkg: definitions shared by the Simon game blocks.
//   state_t     - flasher FSM encoding (IDLE=0, GAP=1, SHOW=2, FINISH=3)
//   CLK_HZ      - board clock frequency
//   DEFAULT_*   - default LED on-time / dark-gap lengths in clock cycles
//   field_width - width of a field able to index n items, never below 1
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_SHOW   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int CLK_HZ             = 50_000_000;
    localparam int DEFAULT_ON_CYCLES  = CLK_HZ;       // 1 s lit
    localparam int DEFAULT_OFF_CYCLES = CLK_HZ / 2;   // 0.5 s dark

    // Used for SYM_W = field_width(CHANNELS) and IDX_W = field_width(MAX_LEN).
    function automatic int field_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simon_sequence_flasher_if.sv
// simon_sequence_flasher_if: control/data bundle between the game FSM and
// the sequence flasher.
//   master (game FSM): drives start, abort, seq_len, seq_data;
//                      observes led, step_idx, busy, done.
//   slave  (flasher) : the mirror image.
interface simon_sequence_flasher_if
    import simon_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MAX_LEN  = 16
);
    localparam int SYM_W = field_width(CHANNELS);
    localparam int IDX_W = field_width(MAX_LEN);

    logic                     start;
    logic                     abort;
    logic [IDX_W:0]           seq_len;
    logic [MAX_LEN*SYM_W-1:0] seq_data;
    logic [CHANNELS-1:0]      led;
    logic [IDX_W-1:0]         step_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output start, abort, seq_len, seq_data,
        input  led, step_idx, busy, done
    );

    modport slave (
        input  start, abort, seq_len, seq_data,
        output led, step_idx, busy, done
    );

endinterface

// File: rtl/simon_sequence_flasher_interval_timer.sv
// interval_timer: free-running up-counter that restarts at limit-1.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   clear        - hold the count at 0
//   limit        - interval length in cycles (WIDTH+1 bits so the value
//                  2**WIDTH itself fits)
//   expire       - high for the single cycle in which count = limit-1
// Comparing against limit-1 means the count never needs to reach limit,
// so WIDTH = clog2(longest interval) is enough and it never wraps.
module interval_timer #(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic [WIDTH:0] limit,
    output logic           expire
);
    logic [WIDTH-1:0] count_q;

    assign expire = ({1'b0, count_q} == (limit - 1'b1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || expire) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/simon_sequence_flasher.sv
// simon_sequence_flasher: plays a stored Simon sequence on one-hot LEDs.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   bus (slave)  - start/abort request, seq_len/seq_data snapshot source,
//                  led/step_idx/busy/done status (all registered)
// Each step is OFF_CYCLES dark followed by ON_CYCLES with the step's
// colour lit. done pulses for one cycle after the last step; abort drops
// straight back to IDLE without a done pulse.
module simon_sequence_flasher
    import simon_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    simon_sequence_flasher_if.slave   bus
);
    localparam int SYM_W = field_width(CHANNELS);
    localparam int IDX_W = field_width(MAX_LEN);
    localparam int TMR_W = field_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);

    localparam logic [IDX_W:0] MAX_LEN_V = (IDX_W + 1)'(MAX_LEN);
    localparam logic [TMR_W:0] ON_LIMIT  = (TMR_W + 1)'(ON_CYCLES);
    localparam logic [TMR_W:0] OFF_LIMIT = (TMR_W + 1)'(OFF_CYCLES);

    state_t                   state_q, state_d;
    logic [IDX_W:0]           len_q, len_d;
    logic [MAX_LEN*SYM_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CHANNELS-1:0]      led_q, led_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     timer_clear;
    logic [TMR_W:0]           timer_limit;
    logic                     timer_expire;
    logic [IDX_W:0]           len_clamped;
    logic [SYM_W-1:0]         sym_arr [MAX_LEN];
    logic [SYM_W-1:0]         cur_sym;

    // Unpacked view of the snapshot so a step can be selected by index.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_sym
        assign sym_arr[gi] = seq_q[gi*SYM_W +: SYM_W];
    end

    assign len_clamped = (bus.seq_len > MAX_LEN_V) ? MAX_LEN_V : bus.seq_len;

    // The timer only runs while a step is in progress; it is held at zero
    // elsewhere so every playback starts with a fresh count.
    assign timer_clear = ((state_q != ST_GAP) && (state_q != ST_SHOW)) || bus.abort;
    assign timer_limit = (state_q == ST_SHOW) ? ON_LIMIT : OFF_LIMIT;

    interval_timer #(.WIDTH(TMR_W)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .limit  (timer_limit),
        .expire (timer_expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        seq_d   = seq_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    seq_d   = bus.seq_data;
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = (len_clamped == '0) ? ST_FINISH : ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_expire) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (timer_expire) begin
                    if ({1'b0, idx_q} == (len_q - 1'b1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start seen in IDLE, so
        // no snapshot is taken and step_idx keeps its value.
        if (bus.abort) begin
            state_d = ST_IDLE;
            len_d   = len_q;
            seq_d   = seq_q;
            idx_d   = idx_q;
        end
    end

    // Outputs are decoded from the next state so the registered LEDs line
    // up exactly with the state they describe.
    assign cur_sym = sym_arr[idx_d];

    always_comb begin
        busy_d = (state_d == ST_GAP) || (state_d == ST_SHOW);
        done_d = (state_d == ST_FINISH);
        led_d  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // Symbols >= CHANNELS match no bit and leave the LEDs dark.
            led_d[c] = (state_d == ST_SHOW) && (int'(cur_sym) == c);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.step_idx = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_simon_sequence_flasher.sv
// Testbench for simon_sequence_flasher with CHANNELS=4, MAX_LEN=8, ON=4,
// OFF=2. Expected per-cycle outputs are pushed to a queue when a start is
// driven and popped on every falling edge. The cycle in which start is
// sampled is cycle 0; the first falling edge after it is cycle 1.
module tb_simon_sequence_flasher;

    typedef struct {
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    simon_sequence_flasher_if #(.CHANNELS(4), .MAX_LEN(8)) bus ();

    simon_sequence_flasher #(
        .CHANNELS   (4),
        .MAX_LEN    (8),
        .ON_CYCLES  (4),
        .OFF_CYCLES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Timeline from the start cycle: L steps of 2 dark + 4 lit cycles, then
    // one done cycle, then two idle cycles with step_idx held.
    function automatic void push_trace(input int len, input logic [15:0] data);
        int         l;
        exp_t       e;
        logic [1:0] sym;
        l = (len > 8) ? 8 : len;
        for (int k = 0; k < l; k++) begin
            sym = data[k*2 +: 2];
            for (int c = 0; c < 2; c++) begin
                e.led = 4'b0000; e.busy = 1'b1; e.done = 1'b0; e.idx = 3'(k);
                exp_q.push_back(e);
            end
            for (int c = 0; c < 4; c++) begin
                e.led = 4'b0001 << sym; e.busy = 1'b1; e.done = 1'b0; e.idx = 3'(k);
                exp_q.push_back(e);
            end
        end
        e.led = 4'b0000; e.busy = 1'b0; e.done = 1'b1; e.idx = (l == 0) ? 3'd0 : 3'(l - 1);
        exp_q.push_back(e);
        e.done = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.seq_len = '0; bus.seq_data = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.led, bus.busy, bus.done, bus.step_idx} !== 9'b0) begin
            errors++;
            $display("FAIL reset_hold led=%b busy=%b done=%b idx=%0d, want all zero",
                     bus.led, bus.busy, bus.done, bus.step_idx);
        end
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.led, bus.busy, bus.done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d led=%b busy=%b done=%b, want 0000/0/0",
                         i, bus.led, bus.busy, bus.done);
            end
        end
        $display("tx reset: 20 idle cycles observed");
    endtask

    task automatic test_sequence(input string name, input int len, input logic [15:0] data);
        exp_t e;
        int   cyc = 0;
        @(negedge clock);
        bus.seq_len = 4'(len); bus.seq_data = data; bus.start = 1'b1;
        push_trace(len, data);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done || bus.step_idx !== e.idx) begin
                errors++;
                $display("FAIL %s cyc%0d got led=%b busy=%b done=%b idx=%0d want led=%b busy=%b done=%b idx=%0d",
                         name, cyc, bus.led, bus.busy, bus.done, bus.step_idx, e.led, e.busy, e.done, e.idx);
            end
            if (cyc == 1) bus.start = 1'b0;
        end
        $display("tx %s: len=%0d data=%h played over %0d cycles", name, len, data, cyc);
    endtask

    task automatic test_abort();
        exp_t e;
        int   cyc = 0;
        @(negedge clock);
        bus.seq_len = 4'd4; bus.seq_data = 16'h00E4; bus.start = 1'b1;
        push_trace(4, 16'h00E4);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        e.led = 4'b0000; e.busy = 1'b0; e.done = 1'b0; e.idx = 3'd1;
        exp_q.push_back(e);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done || bus.step_idx !== e.idx) begin
                errors++;
                $display("FAIL abort cyc%0d got led=%b busy=%b done=%b idx=%0d want led=%b busy=%b done=%b idx=%0d",
                         cyc, bus.led, bus.busy, bus.done, bus.step_idx, e.led, e.busy, e.done, e.idx);
            end
            if (cyc == 1)  bus.start = 1'b0;
            if (cyc == 10) bus.abort = 1'b1;
            if (cyc == 11) bus.abort = 1'b0;
        end
        // Cycle 12: still idle, no late done; start here replays from step 0.
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.led !== 4'b0000) begin
            errors++;
            $display("FAIL abort_nodone cyc12 got led=%b busy=%b done=%b want 0000/0/0",
                     bus.led, bus.busy, bus.done);
        end
        bus.start = 1'b1;
        push_trace(4, 16'h00E4);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done || bus.step_idx !== e.idx) begin
                errors++;
                $display("FAIL replay cyc%0d got led=%b busy=%b done=%b idx=%0d want led=%b busy=%b done=%b idx=%0d",
                         cyc, bus.led, bus.busy, bus.done, bus.step_idx, e.led, e.busy, e.done, e.idx);
            end
            if (cyc == 1) bus.start = 1'b0;
        end
        $display("tx abort: aborted in cycle 10, replay of len=4 completed");
    endtask

    task automatic test_ignore_inputs();
        exp_t e;
        int   cyc = 0;
        @(negedge clock);
        bus.seq_len = 4'd3; bus.seq_data = 16'h0039; bus.start = 1'b1;
        push_trace(3, 16'h0039);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done || bus.step_idx !== e.idx) begin
                errors++;
                $display("FAIL ignore cyc%0d got led=%b busy=%b done=%b idx=%0d want led=%b busy=%b done=%b idx=%0d",
                         cyc, bus.led, bus.busy, bus.done, bus.step_idx, e.led, e.busy, e.done, e.idx);
            end
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 5) bus.start = 1'b1;
            if (cyc == 6) bus.start = 1'b0;
            if (cyc == 8) begin
                bus.seq_data = 16'h0000;
                bus.seq_len  = 4'd1;
            end
            if (cyc == 14) bus.start = 1'b1;
            if (cyc == 15) bus.start = 1'b0;
        end
        $display("tx ignore: mid-playback start and data change left pattern unchanged");
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   cyc = 0;
        bit   hit = 1'b0;
        @(negedge clock);
        bus.seq_len = 4'd2; bus.seq_data = 16'h0009; bus.start = 1'b1;
        push_trace(2, 16'h0009);
        while (exp_q.size() > 0 && !hit) begin
            @(negedge clock);
            cyc++;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done || bus.step_idx !== e.idx) begin
                errors++;
                $display("FAIL areset cyc%0d got led=%b busy=%b done=%b idx=%0d want led=%b busy=%b done=%b idx=%0d",
                         cyc, bus.led, bus.busy, bus.done, bus.step_idx, e.led, e.busy, e.done, e.idx);
            end
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 4) begin
                // Mid-SHOW: raise reset between edges and look before the next rise.
                #2 reset = 1'b1;
                #1;
                checks++;
                if ({bus.led, bus.busy, bus.done, bus.step_idx} !== 9'b0) begin
                    errors++;
                    $display("FAIL areset_async led=%b busy=%b done=%b idx=%0d, want all zero before edge",
                             bus.led, bus.busy, bus.done, bus.step_idx);
                end
                hit = 1'b1;
            end
        end
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.led, bus.busy, bus.done} !== 6'b0) begin
            errors++;
            $display("FAIL areset_after led=%b busy=%b done=%b, want 0000/0/0",
                     bus.led, bus.busy, bus.done);
        end
        $display("tx async_reset: reset in SHOW cleared outputs immediately");
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_sequence("seq3", 3, 16'h0032);
        test_sequence("empty", 0, 16'h00FF);
        test_sequence("clamp", 15, 16'hB1E4);
        test_abort();
        test_ignore_inputs();
        test_sequence("back_to_back", 2, 16'h000D);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
